// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: family-key constants, key-schedule FSM encoding and
// the rotate / L' helpers that both the key schedule and round datapath use.
package sm4_pkg;

  localparam logic [31:0] FK0 = 32'hA3B1BAC6;
  localparam logic [31:0] FK1 = 32'h56AA3350;
  localparam logic [31:0] FK2 = 32'h677D9197;
  localparam logic [31:0] FK3 = 32'hB27022DC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } ks_state_e;

  // Left rotate of a 32-bit word, amount taken modulo 32.
  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] dbl;
    dbl = {x, x} << n;
    return dbl[63:32];
  endfunction

  // Key-schedule linear transform L'(B) = B ^ (B<<<13) ^ (B<<<23).
  function automatic logic [31:0] l_key(input logic [31:0] b);
    return b ^ rotl32(b, 5'd13) ^ rotl32(b, 5'd23);
  endfunction

endpackage

// File: rtl/sm4_sbox.sv
// Combinational 8-bit SM4 S-box, used four times per tau() application.
module sm4_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [7:0] SBOX [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  assign dout = SBOX[din];

endmodule

// File: rtl/sm4_key_expand.sv
// SM4 key schedule: expands a 128-bit master key into rk0..rk31, one key per
// cycle, using an external registered CK lookup addressed one round ahead.
module sm4_key_expand
  import sm4_pkg::*;
#(
  parameter int NUM_ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [127:0] mk_i,
  output logic [5:0]   count_round_o,
  input  logic [31:0]  cki_i,
  output logic         busy_o,
  output logic         rk_valid_o,
  output logic [31:0]  rk_o,
  output logic [4:0]   rk_idx_o,
  output logic         done_o
);

  ks_state_e   state_q, state_d;
  logic [31:0] k_q [4];
  logic [4:0]  r_q;
  logic        last_round;
  logic [31:0] t_word, b_word, rk_next;

  assign last_round = (r_q == 5'(NUM_ROUNDS - 1));

  // Round function: T = K1^K2^K3^CK_r, B = tau(T), rk = K0 ^ L'(B).
  assign t_word = k_q[1] ^ k_q[2] ^ k_q[3] ^ cki_i;

  for (genvar g = 0; g < 4; g++) begin : g_tau
    sm4_sbox u_sbox (
      .din  (t_word[8*g +: 8]),
      .dout (b_word[8*g +: 8])
    );
  end

  assign rk_next = k_q[0] ^ l_key(b_word);

  // Next-state and lookup address; CK index runs one round ahead of r.
  always_comb begin
    state_d       = state_q;
    count_round_o = 6'd0;
    busy_o        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        busy_o  = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        busy_o        = 1'b1;
        count_round_o = {1'b0, r_q} + 6'd1;
        if (last_round) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, key shift register, round counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      for (int i = 0; i < 4; i++) k_q[i] <= '0;
      r_q        <= '0;
      rk_valid_o <= 1'b0;
      rk_o       <= '0;
      rk_idx_o   <= '0;
      done_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rk_valid_o <= 1'b0;
      done_o     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            k_q[0] <= mk_i[127:96] ^ FK0;
            k_q[1] <= mk_i[95:64]  ^ FK1;
            k_q[2] <= mk_i[63:32]  ^ FK2;
            k_q[3] <= mk_i[31:0]   ^ FK3;
            r_q    <= '0;
          end
        end
        ST_RUN: begin
          k_q[0]     <= k_q[1];
          k_q[1]     <= k_q[2];
          k_q[2]     <= k_q[3];
          k_q[3]     <= rk_next;
          rk_o       <= rk_next;
          rk_idx_o   <= r_q;
          rk_valid_o <= 1'b1;
          done_o     <= last_round;
          r_q        <= r_q + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sm4_key_expand.sv
// Bench for sm4_key_expand: models the registered CK lookup, checks timing,
// ordering and key values against an array-based key-schedule model.
module tb_sm4_key_expand;

  typedef logic [31:0] keys_t [32];
  typedef struct {
    logic [127:0] mk;
    logic [31:0]  rk0;
    logic [31:0]  rk1;
    logic [31:0]  rk31;
  } vec_t;

  localparam logic [127:0] STD_MK = 128'h0123456789ABCDEFFEDCBA9876543210;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [127:0] mk_i;
  logic [5:0]   count_round_o;
  logic [31:0]  cki_i = '0;
  logic         busy_o;
  logic         rk_valid_o;
  logic [31:0]  rk_o;
  logic [4:0]   rk_idx_o;
  logic         done_o;

  int tests = 0;
  int fails = 0;

  logic [7:0] sbox_ref [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  always #5 clk = ~clk;

  sm4_key_expand #(.NUM_ROUNDS(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .mk_i          (mk_i),
    .count_round_o (count_round_o),
    .cki_i         (cki_i),
    .busy_o        (busy_o),
    .rk_valid_o    (rk_valid_o),
    .rk_o          (rk_o),
    .rk_idx_o      (rk_idx_o),
    .done_o        (done_o)
  );

  // CK_i byte j = (4i+j)*7 mod 256, most significant byte first.
  function automatic logic [31:0] ck_word(input int n);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[31-8*j -: 8] = 8'(((4*n + j) * 7) % 256);
    return w;
  endfunction

  // Registered CK lookup standing in for get_cki.
  always @(posedge clk) cki_i <= ck_word(int'(count_round_o));

  function automatic logic [31:0] rot(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  task automatic ref_expand(input logic [127:0] mk, output keys_t rk);
    logic [31:0] kw [36];
    logic [31:0] fk [4];
    logic [31:0] t, b;
    fk[0] = 32'hA3B1BAC6; fk[1] = 32'h56AA3350; fk[2] = 32'h677D9197; fk[3] = 32'hB27022DC;
    for (int i = 0; i < 4; i++) kw[i] = mk[127-32*i -: 32] ^ fk[i];
    for (int i = 0; i < 32; i++) begin
      t = kw[i+1] ^ kw[i+2] ^ kw[i+3] ^ ck_word(i);
      for (int j = 0; j < 4; j++) b[8*j +: 8] = sbox_ref[t[8*j +: 8]];
      kw[i+4] = kw[i] ^ b ^ rot(b, 13) ^ rot(b, 23);
      rk[i] = kw[i+4];
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch a schedule and observe 34 cycles up to and including the done cycle.
  task automatic run_sched(input logic [127:0] mk, input bit perturb, output keys_t ks,
                           output int nvalid, output int first_v, output int done_at);
    nvalid = 0; first_v = -1; done_at = -1;
    for (int i = 0; i < 32; i++) ks[i] = '0;
    mk_i = mk; start_i = 1'b1;
    tick;
    start_i = 1'b0;
    mk_i = {$urandom, $urandom, $urandom, $urandom};
    for (int cyc = 1; cyc <= 34; cyc++) begin
      chk("busy", busy_o, (cyc <= 33));
      chk("count_round", count_round_o, (cyc <= 33) ? cyc - 1 : 0);
      chk("done", done_o, (cyc == 34));
      if (rk_valid_o) begin
        if (first_v < 0) first_v = cyc;
        chk("rk_idx", rk_idx_o, nvalid);
        ks[rk_idx_o] = rk_o;
        nvalid++;
      end
      if (done_o) begin
        done_at = cyc;
        chk("done_idx", rk_idx_o, 31);
      end
      if (cyc < 34) begin
        if (perturb && cyc == 12) begin
          start_i = 1'b1; mk_i = ~mk;
          tick;
          start_i = 1'b0;
        end else begin
          tick;
        end
      end
    end
  endtask

  task automatic check_stream(input string tag, input logic [127:0] mk, input keys_t ks,
                              input int nvalid, input int first_v, input int done_at);
    keys_t exp;
    ref_expand(mk, exp);
    chk({tag, "_nvalid"}, nvalid, 32);
    chk({tag, "_first_valid"}, first_v, 3);
    chk({tag, "_done_at"}, done_at, 34);
    for (int i = 0; i < 32; i++) chk($sformatf("%s_rk%0d", tag, i), ks[i], exp[i]);
  endtask

  initial begin
    vec_t  vecs [3];
    keys_t ks, ks2, mkeys;
    int    nv, fv, da, seen;
    logic [127:0] rmk;

    rst_n = 1'b0; start_i = 1'b0; mk_i = '0;
    repeat (3) tick;
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", rk_valid_o, 0);
    chk("rst_rk", rk_o, 0);
    chk("rst_idx", rk_idx_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_count", count_round_o, 0);
    rst_n = 1'b1;
    tick;

    // Vector table: the published vector plus model-derived entries.
    vecs[0] = '{mk: STD_MK, rk0: 32'hF12186F9, rk1: 32'h41662B61, rk31: 32'h9124A012};
    vecs[1].mk = '1;
    vecs[2].mk = 128'h00112233445566778899AABBCCDDEEFF;
    for (int v = 1; v < 3; v++) begin
      ref_expand(vecs[v].mk, mkeys);
      vecs[v].rk0 = mkeys[0]; vecs[v].rk1 = mkeys[1]; vecs[v].rk31 = mkeys[31];
    end
    for (int v = 0; v < 3; v++) begin
      run_sched(vecs[v].mk, 1'b0, ks, nv, fv, da);
      chk($sformatf("vec%0d_rk0", v), ks[0], vecs[v].rk0);
      chk($sformatf("vec%0d_rk1", v), ks[1], vecs[v].rk1);
      chk($sformatf("vec%0d_rk31", v), ks[31], vecs[v].rk31);
      check_stream($sformatf("vec%0d", v), vecs[v].mk, ks, nv, fv, da);
      tick;
      chk("valid_after_done", rk_valid_o, 0);
      chk("busy_after_done", busy_o, 0);
    end

    // start_i during round 10 must be ignored.
    run_sched(STD_MK, 1'b1, ks, nv, fv, da);
    check_stream("perturb", STD_MK, ks, nv, fv, da);
    tick;

    // Reset during round 15 aborts immediately with no done_o.
    mk_i = STD_MK; start_i = 1'b1;
    tick;
    start_i = 1'b0;
    repeat (16) tick;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy_o, 0);
    chk("abort_valid", rk_valid_o, 0);
    chk("abort_rk", rk_o, 0);
    chk("abort_idx", rk_idx_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_count", count_round_o, 0);
    repeat (2) tick;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (done_o || rk_valid_o) seen++;
    end
    chk("abort_no_output", seen, 0);
    run_sched(STD_MK, 1'b0, ks, nv, fv, da);
    check_stream("after_abort", STD_MK, ks, nv, fv, da);

    // Back-to-back: second start in the done cycle with mk=0.
    run_sched('0, 1'b0, ks2, nv, fv, da);
    check_stream("b2b", '0, ks2, nv, fv, da);
    tick;
    chk("b2b_valid_after_done", rk_valid_o, 0);

    // Random master keys against the model.
    for (int n = 0; n < 1000; n++) begin
      rmk = {$urandom, $urandom, $urandom, $urandom};
      run_sched(rmk, 1'b0, ks, nv, fv, da);
      check_stream($sformatf("rand%0d", n), rmk, ks, nv, fv, da);
    end
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
